// File: rtl/event_writer.sv
// event_writer: edge-triggered coincidence capture, writes N_CH 64-bit words per event to a FIFO.
// Optional EVENT_WRITER_ARM_EN adds arm_i to gate trigger acceptance in IDLE.
module event_writer #(
  parameter int N_CH      = 16,
  parameter int WINDOW    = 32,
  parameter int EVT_WIDTH = 24
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [N_CH-1:0] hits_i,
  input  logic            full_i,
`ifdef EVENT_WRITER_ARM_EN
  input  logic            arm_i,
`endif
  output logic            wr_en_o,
  output logic [63:0]     din_o,
  output logic            busy_o,
  output logic [15:0]     lost_o
);
  localparam int IW = $clog2(N_CH);
  localparam int CW = $clog2(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_WIN, S_WRITE} state_t;

  state_t                 r_state;
  logic [N_CH-1:0]        r_hits_q, r_hit, r_multi;
  logic [31:0]            r_ts;
  logic [31:0]            r_ts_cap [N_CH];
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [EVT_WIDTH-1:0]   r_evt;
  logic [15:0]            r_lost;
  logic [N_CH-1:0]        w_edge;
  logic                   w_wr, w_armed;

`ifdef EVENT_WRITER_ARM_EN
  assign w_armed = arm_i;
`else
  assign w_armed = 1'b1;
`endif

  assign w_edge  = hits_i & ~r_hits_q;
  assign w_wr    = r_state == S_WRITE;
  assign wr_en_o = w_wr & ~full_i;
  assign busy_o  = r_state != S_IDLE;
  assign lost_o  = r_lost;
  assign din_o   = w_wr ? {4'(r_idx), r_hit[r_idx], r_multi[r_idx], 2'b00, 24'(r_evt), r_ts_cap[r_idx]} : '0;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_hits_q <= '0;
      r_hit    <= '0;
      r_multi  <= '0;
      r_ts     <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_evt    <= '0;
      r_lost   <= '0;
      for (int i = 0; i < N_CH; i++) r_ts_cap[i] <= '0;
    end else begin
      r_hits_q <= hits_i;
      r_ts     <= r_ts + 32'd1;
      case (r_state)
        S_IDLE: if (|w_edge && w_armed) begin
          r_state <= S_WIN;
          r_cnt   <= CW'(WINDOW - 2);
          r_hit   <= w_edge;
          for (int i = 0; i < N_CH; i++) if (w_edge[i]) r_ts_cap[i] <= r_ts;
        end
        S_WIN: begin
          // repeat edges only flag multi; the first timestamp is kept
          for (int i = 0; i < N_CH; i++)
            if (w_edge[i]) begin
              if (r_hit[i]) r_multi[i] <= 1'b1;
              else begin
                r_hit[i]    <= 1'b1;
                r_ts_cap[i] <= r_ts;
              end
            end
          if (r_cnt == '0) begin
            r_state <= S_WRITE;
            r_idx   <= '0;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_WRITE: begin
          if (|w_edge && r_lost != 16'hFFFF) r_lost <= r_lost + 16'd1;
          if (wr_en_o) begin
            if (r_idx == IW'(N_CH - 1)) begin
              r_state <= S_IDLE;
              r_evt   <= r_evt + 1'b1;
              r_hit   <= '0;
              r_multi <= '0;
              for (int i = 0; i < N_CH; i++) r_ts_cap[i] <= '0;
            end else r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_event_writer.sv
// tb_event_writer: directed table + randomized run against a queue-based event model.
module tb_event_writer;
  localparam int N = 16;
  localparam int W = 32;

  logic          clk = 0;
  logic          aresetn = 0;
  logic [N-1:0]  hits = '0;
  logic          full = 0;
  logic          arm = 1;
  logic          wr_en_o, busy_o;
  logic [63:0]   din_o;
  logic [15:0]   lost_o;

  event_writer dut (
    .clk(clk), .aresetn(aresetn), .hits_i(hits), .full_i(full),
`ifdef EVENT_WRITER_ARM_EN
    .arm_i(arm),
`endif
    .wr_en_o(wr_en_o), .din_o(din_o), .busy_o(busy_o), .lost_o(lost_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference model: an event is a trigger time plus per-channel first-edge data;
  // its words are queued once the window has elapsed and drained one per accepted write.
  bit           m_act;
  logic [31:0]  m_T, m_ts;
  logic [N-1:0] m_hit, m_multi, m_hq, m_edges;
  logic [31:0]  m_tsc [N];
  logic [63:0]  m_wq [$];
  logic [23:0]  m_evt;
  logic [15:0]  m_lost;
  logic [63:0]  cap [N];
  int           wr_cnt;
  logic [31:0]  first_wr;
  logic         m_armed;

  always @(negedge clk) begin
`ifdef EVENT_WRITER_ARM_EN
    m_armed = arm;
`else
    m_armed = 1'b1;
`endif
    if (!aresetn) begin
      m_act = 0; m_ts = 0; m_hq = '0; m_evt = 0; m_lost = 0; m_wq.delete();
      chk("rst_wr_en", {63'd0, wr_en_o}, 64'd0);
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_lost", {48'd0, lost_o}, 64'd0);
      chk("rst_din", din_o, 64'd0);
    end else begin
      m_edges = hits & ~m_hq;
      if (m_act && m_ts - m_T == 32'(W))
        for (int i = 0; i < N; i++)
          m_wq.push_back({4'(i), m_hit[i], m_multi[i], 2'b00, m_evt, m_hit[i] ? m_tsc[i] : 32'd0});
      chk("busy", {63'd0, busy_o}, {63'd0, m_act});
      chk("wr_en", {63'd0, wr_en_o}, {63'd0, m_wq.size() > 0 && !full});
      chk("din", din_o, m_wq.size() > 0 ? m_wq[0] : 64'd0);
      chk("lost", {48'd0, lost_o}, {48'd0, m_lost});
      if (wr_en_o) begin
        if (wr_cnt == 0) first_wr = m_ts;
        cap[din_o[63:60]] = din_o;
        wr_cnt++;
      end
      if (m_wq.size() > 0) begin
        if (|m_edges && m_lost != 16'hFFFF) m_lost++;
        if (!full) begin
          void'(m_wq.pop_front());
          if (m_wq.size() == 0) begin m_act = 0; m_evt++; end
        end
      end else if (m_act) begin
        for (int i = 0; i < N; i++)
          if (m_edges[i]) begin
            if (m_hit[i]) m_multi[i] = 1;
            else begin m_hit[i] = 1; m_tsc[i] = m_ts; end
          end
      end else if (|m_edges && m_armed) begin
        m_act = 1; m_T = m_ts; m_hit = m_edges; m_multi = '0;
        for (int i = 0; i < N; i++) if (m_edges[i]) m_tsc[i] = m_ts;
      end
      m_hq = hits;
      m_ts++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 aresetn = 0; hits = '0; full = 0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1; wr_cnt = 0;
    for (int i = 0; i < N; i++) cap[i] = 'x;
  endtask

  task automatic at_ts(int t);
    int b = 0;
    while (m_ts != 32'(t) && b < 5000) begin @(posedge clk); #1; b++; end
    if (b >= 5000) chk("at_ts_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse(int ch, int t);
    at_ts(t); hits[ch] = 1;
    @(posedge clk); #1; @(posedge clk); #1; hits[ch] = 0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((m_act || busy_o) && b < 3000) begin @(posedge clk); #1; b++; end
    if (b >= 3000) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    int ch_a, t_a, ch_b, t_b;
    int k0; logic [63:0] e0;
    int k1; logic [63:0] e1;
    int first;
  } vec_t;
  vec_t tbl [3];

  initial begin
    int t;
    tbl[0] = '{3, 100, -1, 0, 3, 64'h3800_0000_0000_0064, 0, 64'h0, 132};
    tbl[1] = '{0, 200, 15, 205, 0, 64'h0800_0000_0000_00C8, 15, 64'hF800_0000_0000_00CD, 232};
    tbl[2] = '{5, 10, 5, 20, 5, 64'h5C00_0000_0000_000A, 4, 64'h4000_0000_0000_0000, 42};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      pulse(tbl[v].ch_a, tbl[v].t_a);
      if (tbl[v].ch_b >= 0) pulse(tbl[v].ch_b, tbl[v].t_b);
      wait_idle();
      chk($sformatf("v%0d_nwrites", v), 64'(wr_cnt), 64'd16);
      chk($sformatf("v%0d_word%0d", v, tbl[v].k0), cap[tbl[v].k0], tbl[v].e0);
      chk($sformatf("v%0d_word%0d", v, tbl[v].k1), cap[tbl[v].k1], tbl[v].e1);
      chk($sformatf("v%0d_first_wr", v), {32'd0, first_wr}, 64'(tbl[v].first));
    end

    // FIFO full during WRITE cycles 3..12
    do_reset();
    pulse(7, 50);
    at_ts(50 + W + 3); full = 1;
    @(negedge clk); #1 chk("stall_wr_en", {63'd0, wr_en_o}, 64'd0);
    @(posedge clk); #1;
    at_ts(50 + W + 13); full = 0;
    wait_idle();
    chk("stall_nwrites", 64'(wr_cnt), 64'd16);
    chk("stall_word7", cap[7], 64'h7800_0000_0000_0032);

    // edge during WRITE is lost and does not start an event
    do_reset();
    pulse(2, 30);
    pulse(1, 30 + W + 4);
    wait_idle();
    chk("lost_one", {48'd0, lost_o}, 64'd1);
    wr_cnt = 0;
    repeat (40) @(posedge clk);
    #1 chk("no_extra_event", 64'(wr_cnt), 64'd0);
    t = int'(m_ts) + 3;
    pulse(9, t);
    wait_idle();
    chk("evt1_nwrites", 64'(wr_cnt), 64'd16);
    chk("evt1_number", {40'd0, cap[9][55:32]}, 64'd1);

    // reset in the middle of WRITE
    do_reset();
    pulse(4, 20);
    for (int b = 0; b < 200 && wr_cnt < 7; b++) @(negedge clk);
    chk("seven_writes", 64'(wr_cnt), 64'd7);
    @(posedge clk); #2 aresetn = 0;
    #1 chk("async_rst_wr_en", {63'd0, wr_en_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1; wr_cnt = 0;
    chk("post_rst_busy", {63'd0, busy_o}, 64'd0);
    pulse(6, 15);
    wait_idle();
    chk("post_rst_word6", cap[6], 64'h6800_0000_0000_000F);

`ifdef EVENT_WRITER_ARM_EN
    do_reset();
    arm = 0;
    pulse(3, 10);
    repeat (40) @(posedge clk);
    #1 chk("disarmed_busy", {63'd0, busy_o}, 64'd0);
    chk("disarmed_lost", {48'd0, lost_o}, 64'd0);
    chk("disarmed_writes", 64'(wr_cnt), 64'd0);
    arm = 1;
    pulse(3, 60);
    wait_idle();
    chk("armed_word3", cap[3], 64'h3800_0000_0000_003C);
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      hits = hits ^ 16'($urandom & $urandom & $urandom & $urandom);
      full = ($urandom_range(0, 3) == 0);
`ifdef EVENT_WRITER_ARM_EN
      arm = ($urandom_range(0, 3) != 0);
`endif
    end
    hits = '0; full = 0; arm = 1;
    wait_idle();
    chk("rand_final_busy", {63'd0, busy_o}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
